// File: rtl/port_wrr_sched_pkg.sv
// Shared definitions for the per-port WRR / strict-priority scheduler:
// FSM state encoding, default sizing and the per-priority credit weights.
package port_wrr_sched_pkg;

    localparam int unsigned NUM_PRIO_DEF = 8;
    localparam int unsigned CRED_W_DEF   = 4;
    localparam int unsigned PRIO_W       = $clog2(NUM_PRIO_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2
    } state_e;

    // WEIGHT[p] = p + 1: higher priorities get proportionally more grants per round.
    function automatic int unsigned prio_weight(input int unsigned p);
        return p + 1;
    endfunction

endpackage

// File: rtl/port_wrr_sched_prio_pick.sv
// Combinational highest-set-bit selector.
//   req_i   : request vector, bit i = candidate i
//   idx_o   : index of the highest set bit (0 when none set)
//   valid_o : at least one bit of req_i is set
module port_wrr_sched_prio_pick #(
    parameter  int unsigned N = 8,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        idx_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/port_wrr_sched.sv
// Output-port packet scheduler: picks one priority queue per packet using
// either strict priority or credit-based weighted round-robin, then runs the
// request/transfer handshake with the read path.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wrr_en      : 1 = weighted round-robin, 0 = strict priority (sampled in IDLE)
//   q_nonempty  : per-priority "holds a whole packet" flags
//   ready       : downstream can take a new packet
//   rd_ack      : read path accepted the request
//   pkt_done    : read path emitted eop for the current packet
//   rd_req      : read request (GRANT state)
//   rd_prio     : queue being requested / transferred
//   busy        : GRANT or XFER
module port_wrr_sched
    import port_wrr_sched_pkg::*;
#(
    parameter  int unsigned NUM_PRIO = 8,
    parameter  int unsigned CRED_W   = 4,
    localparam int unsigned PW       = (NUM_PRIO > 1) ? $clog2(NUM_PRIO) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wrr_en,
    input  logic [NUM_PRIO-1:0] q_nonempty,
    input  logic                ready,
    input  logic                rd_ack,
    input  logic                pkt_done,
    output logic                rd_req,
    output logic [PW-1:0]       rd_prio,
    output logic                busy
);

    state_e                           state_q, state_d;
    logic [PW-1:0]                    rd_prio_q, rd_prio_d;
    logic                             rd_req_q, rd_req_d;
    logic                             busy_q, busy_d;
    logic [NUM_PRIO-1:0][CRED_W-1:0]  credit_q, credit_d;

    logic [NUM_PRIO-1:0] has_credit;
    logic [NUM_PRIO-1:0] pick_req;
    logic [PW-1:0]       pick_idx;
    logic                pick_valid;

    // Per-queue "credit remaining" flags for WRR eligibility.
    always_comb begin
        has_credit = '0;
        for (int unsigned p = 0; p < NUM_PRIO; p++) begin
            has_credit[p] = |credit_q[p];
        end
    end

    // One selector serves both modes; only the eligibility mask differs.
    assign pick_req = wrr_en ? (q_nonempty & has_credit) : q_nonempty;

    port_wrr_sched_prio_pick #(
        .N (NUM_PRIO)
    ) u_pick (
        .req_i   (pick_req),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Next-state, grant decision and credit update.
    always_comb begin
        state_d   = state_q;
        rd_prio_d = rd_prio_q;
        credit_d  = credit_q;

        case (state_q)
            ST_IDLE: begin
                if (ready) begin
                    if (pick_valid) begin
                        state_d   = ST_GRANT;
                        rd_prio_d = pick_idx;
                        if (wrr_en) begin
                            credit_d[pick_idx] = credit_q[pick_idx] - CRED_W'(1);
                        end
                    end else if (wrr_en && (|q_nonempty)) begin
                        // Every backlogged queue is out of credit: start a new round.
                        for (int unsigned p = 0; p < NUM_PRIO; p++) begin
                            credit_d[p] = CRED_W'(prio_weight(p));
                        end
                    end
                end
            end
            ST_GRANT: begin
                if (rd_ack) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (pkt_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_req_d = (state_d == ST_GRANT);
        busy_d   = (state_d != ST_IDLE);
    end

    // State, output and credit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_prio_q <= '0;
            rd_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            for (int unsigned p = 0; p < NUM_PRIO; p++) begin
                credit_q[p] <= CRED_W'(prio_weight(p));
            end
        end else begin
            state_q   <= state_d;
            rd_prio_q <= rd_prio_d;
            rd_req_q  <= rd_req_d;
            busy_q    <= busy_d;
            credit_q  <= credit_d;
        end
    end

    assign rd_req  = rd_req_q;
    assign rd_prio = rd_prio_q;
    assign busy    = busy_q;

endmodule

// File: doc/port_wrr_sched.md
PORT_WRR_SCHED -- requirements
Module: port_wrr_sched

Interface
REQ-001 SHALL have parameter NUM_PRIO, default 8, giving the number of priority queues per output port.
REQ-002 SHALL have parameter CRED_W, default 4, giving the width of each per-queue credit counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port wrr_en, input, 1 bit: 1 selects weighted round-robin, 0 selects strict priority.
REQ-006 SHALL have port q_nonempty, input, NUM_PRIO bits: bit p is 1 when priority-p queue holds at least one whole packet.
REQ-007 SHALL have port ready, input, 1 bit: downstream port accepts a new packet.
REQ-008 SHALL have port rd_ack, input, 1 bit: read path accepted the current request.
REQ-009 SHALL have port pkt_done, input, 1 bit: read path emitted eop for the current packet.
REQ-010 SHALL have port rd_req, output, 1 bit: read request to the read path.
REQ-011 SHALL have port rd_prio, output, log2(NUM_PRIO) bits: queue being requested or transferred.
REQ-012 SHALL have port busy, output, 1 bit: 1 in states GRANT and XFER.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, GRANT and XFER.
REQ-014 In IDLE with ready=1 and an eligible queue, SHALL register rd_prio and move to GRANT on the next edge.
REQ-015 Strict mode: eligible = q_nonempty; SHALL choose the highest-numbered eligible priority.
REQ-016 WRR mode: eligible = q_nonempty AND credit>0; SHALL choose the highest-numbered eligible priority and decrement its credit by 1 on the IDLE->GRANT edge.
REQ-017 WRR mode, IDLE, q_nonempty!=0 but no nonempty queue has credit: SHALL reload every credit to WEIGHT[p] on that edge, grant nothing, and stay in IDLE (one bubble cycle).
REQ-018 Credits SHALL NOT change in strict mode.
REQ-019 wrr_en SHALL be sampled only in IDLE; changes during GRANT or XFER take effect at the next decision.
REQ-020 GRANT: SHALL assert rd_req=1 with rd_prio stable until rd_ack=1, then move to XFER on that edge.
REQ-021 XFER: SHALL hold rd_req=0 and rd_prio stable until pkt_done=1, then return to IDLE on that edge.
REQ-022 rd_ack outside GRANT and pkt_done outside XFER SHALL be ignored.
REQ-023 ready=0 in IDLE SHALL block all grants and reloads; ready in GRANT and XFER SHALL be ignored.
REQ-024 With q_nonempty=0 in IDLE, SHALL stay idle and leave credits unchanged.
REQ-025 Minimum packet turnaround is 3 cycles (IDLE, GRANT with rd_ack, XFER with pkt_done).
REQ-026 Credit arithmetic SHALL be unsigned CRED_W bits and SHALL never decrement below 0.

Reset
REQ-027 While rst_n=0: state=IDLE, rd_req=0, rd_prio=0, busy=0, credit[p]=WEIGHT[p]; this SHALL apply immediately, without waiting for clk.
REQ-028 Reset asserted in GRANT or XFER SHALL abandon the packet; no grant state is retained.

Structure
REQ-029 The shared hydra package SHALL define: the state enum (IDLE, GRANT, XFER); WEIGHT[p]=p+1 for p=0..7; and the priority-index width.
REQ-030 SHALL instantiate one sub-module, prio_pick: combinational highest-set-bit selector, NUM_PRIO in, index plus valid out, shared by both modes.

Verification
REQ-031 Reset check: rst_n low mid-run -> rd_req=0, busy=0, rd_prio=0, credits {8,7,6,5,4,3,2,1} (p7..p0) with no clock edge.
REQ-032 Strict mode: wrr_en=0, q_nonempty=8'h81, ready=1, rd_ack and pkt_done returned 1 cycle after each request -> 10 consecutive grants all rd_prio=7; credits unchanged.
REQ-033 WRR mode: wrr_en=1, q_nonempty=8'h81 held, prompt ack/done -> per round 8 grants prio7 then 1 grant prio0, then one bubble cycle with rd_req=0 and credits reloaded; pattern repeats.
REQ-034 Handshake stall: rd_ack held 0 for 5 cycles in GRANT -> rd_req=1 and rd_prio constant for all 5 cycles; XFER entered on the rd_ack cycle.
REQ-035 Ready gating: ready=0 with q_nonempty=8'hFF for 10 cycles -> rd_req=0, busy=0, credits unchanged; ready=1 -> GRANT with rd_prio=7 on the next edge.
REQ-036 Mode switch: wrr_en toggled 1->0 during XFER -> current packet completes unchanged; next decision is strict priority.
